parallel_bit_streamer: RTL and testbench
========================================

# parallel_bit_streamer

Parallel-to-serial converter for the delta-sigma path: accepts 8-bit words over a valid/ready handshake and emits them as a serial bit stream, one bit per bit period, LSB first. It feeds the DAC/loopback side of the delta-sigma chain. It produces the same bit ordering that the ADC-side deserializer consumes, where bit 0 arrives first. A one-word holding register lets back-to-back words stream with no gap.

## Interface
- DATA_WIDTH, 8: word width; must be ≥ 2.
- BIT_PERIOD, 1: clock cycles each bit is held on serialOut; must be ≥ 1.
- IDLE_LEVEL, 1'b0: serialOut value when no word is being shifted.

- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- dataIn  in  DATA_WIDTH  parallel word to transmit.
- dataValid  in  1  dataIn is valid.
- dataReady  out  1  holding register is empty, so a word can be accepted.
- serialOut  out  1  current serial bit.
- bitStrobe  out  1  one-cycle pulse in the first cycle of each new bit.
- frameStart  out  1  one-cycle pulse coincident with the bitStrobe of bit 0.
- wordDone  out  1  one-cycle pulse in the last cycle of the last bit of a word.
- busy  out  1  high while in SHIFT.

## Operation
- Handshake: a word is accepted on any rising edge where dataValid && dataReady. On acceptance, dataIn is captured into the holding register and holdFull is set.
  - dataReady = !holdFull. It is registered-state-derived, with no combinational path from dataValid.
  - dataValid while dataReady is low is ignored; the producer holds its data.
- State machine with states IDLE and SHIFT:
  - IDLE:
    - serialOut = IDLE_LEVEL and busy = 0.
    - If holdFull: copy the holding register into the shift register, clear holdFull, and go to SHIFT with bit index 0.
  - SHIFT:
    - serialOut = shift[bitIdx].
    - periodCnt counts 0..BIT_PERIOD-1; bitIdx advances when periodCnt wraps.
    - In the last cycle of bit DATA_WIDTH-1:
      - wordDone = 1.
      - If holdFull: reload from the holding register, clear holdFull, set bitIdx = 0, and stay in SHIFT. This is the gapless case.
      - Otherwise go to IDLE.
- Simultaneous events:
  - Drain and accept cannot happen in the same cycle, because dataReady is low whenever holdFull is set.
  - Accept in the same cycle as the IDLE→SHIFT transition is impossible for the same reason.
- Counter widths:
  - bitIdx is $clog2(DATA_WIDTH) bits.
  - periodCnt is max(1, $clog2(BIT_PERIOD)) bits.
  - Both wrap modulo their terminal counts and never exceed them.
- Reset values (rst applies synchronously, including mid-word):
  - state is IDLE; holdFull, bitIdx and periodCnt are 0.
  - dataReady = 1 (the cycle after rst deasserts).
  - serialOut = IDLE_LEVEL.
  - bitStrobe, frameStart, wordDone and busy are 0.
  - Any partial word and any held word are discarded.

## Timing
- Word accepted at edge N (from IDLE, empty): holdFull is set after N, and dataReady goes low in cycle N+1.
- At edge N+1 the FSM enters SHIFT. In cycle N+1 to N+2: serialOut = bit 0, bitStrobe = frameStart = 1, busy = 1, and dataReady is high again.
- Latency from acceptance to the first bit on serialOut is 1 cycle.
- A word occupies exactly DATA_WIDTH×BIT_PERIOD cycles of SHIFT.
- Gapless streaming: bit 0 of the next word follows the last bit of the previous word in the immediately following cycle. This holds as long as the producer refills the holding register before the word ends, which needs at least 2 cycles; that is guaranteed because DATA_WIDTH ≥ 2.
- All outputs are registered.

## Structure
- Shared package delta_sigma_pkg holds:
  - the state enum (IDLE, SHIFT);
  - ADC_WORD_WIDTH = 8, used as the DATA_WIDTH default on both the ADC and DAC sides.
- One natural sub-module is bit_period_timer. It holds periodCnt, with inputs clear and enable and outputs firstCycle and lastCycle, and generates bitStrobe and the advance condition.
- The FSM, holding register and shift register live in the top module.

## Test plan
- Reset, then idle: after rst, dataReady = 1, serialOut = 0, busy = 0, and all pulses are 0 for 20 cycles.
- Single word with BIT_PERIOD = 1: send 8'hA5.
  - serialOut is 1,0,1,0,0,1,0,1 on cycles N+1..N+8.
  - frameStart is high at N+1 only and wordDone is high at N+8 only.
  - FSM returns to IDLE at N+9.
- Back-to-back: dataValid held high with 8'h01 then 8'hFF. The 16 bits 1,0,0,0,0,0,0,0,1×8 appear with no idle cycle between words, and frameStart pulses exactly twice.
- BIT_PERIOD = 3: send 8'h80.
  - Each bit is held 3 cycles; bitStrobe pulses every 3rd cycle.
  - serialOut = 1 only in cycles 22–24 after start, and the word takes 24 cycles total.
- Backpressure: with the shift register busy and the holding register full, present 8'h3C. dataReady stays low and the word is not captured until the current word's last cycle frees the holding register.
- Reset mid-word: assert rst during bit 4 of 8'hF0 with a second word held. serialOut = 0 on the next cycle, neither word is ever emitted, and the next word accepted starts cleanly at bit 0.

Source files
------------

// File: rtl/delta_sigma_pkg.sv
// delta_sigma_pkg: shared types and constants for the delta-sigma chain
package delta_sigma_pkg;
  localparam int ADC_WORD_WIDTH = 8;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bit_period_timer.sv
// bit_period_timer: counts the cycles of one bit period and flags its first and last cycle
module bit_period_timer
  import delta_sigma_pkg::*;
#(
  parameter int BIT_PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic first_cycle,
  output logic last_cycle,
  output logic last_ahead
);
  localparam int CW = cnt_width(BIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);
  logic [CW-1:0] cnt, cnt_n;
  // clear and enable describe the coming cycle, so the flags are registered for it
  always_comb begin
    cnt_n = (clear || !enable || last_cycle) ? '0 : cnt + CW'(1);
    last_ahead = enable && cnt_n == LAST;
  end
  // period counter and registered first/last cycle flags
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      first_cycle <= 1'b0;
      last_cycle <= 1'b0;
    end else begin
      cnt <= cnt_n;
      first_cycle <= enable && cnt_n == '0;
      last_cycle <= last_ahead;
    end
endmodule

// File: rtl/parallel_bit_streamer.sv
// parallel_bit_streamer: valid/ready word input, LSB-first serial output with one-word holding register
module parallel_bit_streamer
  import delta_sigma_pkg::*;
#(
  parameter int   DATA_WIDTH = ADC_WORD_WIDTH,
  parameter int   BIT_PERIOD = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataValid,
  output logic                  dataReady,
  output logic                  serialOut,
  output logic                  bitStrobe,
  output logic                  frameStart,
  output logic                  wordDone,
  output logic                  busy
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] hold, shift, shift_n;
  logic [IW-1:0] idx, idx_n;
  logic ready_n, load, adv, word_end, last_cycle, last_ahead;
  bit_period_timer #(.BIT_PERIOD(BIT_PERIOD)) timer (
    .clk(clk),
    .rst(rst),
    .clear(load),
    .enable(state_n == SHIFT),
    .first_cycle(bitStrobe),
    .last_cycle(last_cycle),
    .last_ahead(last_ahead)
  );
  // next state: a full holding register is drained when idle or at the end of a word
  always_comb begin
    adv = state == SHIFT && last_cycle;
    word_end = adv && idx == LAST_BIT;
    load = !dataReady && (state == IDLE || word_end);
    ready_n = load || (dataReady && !dataValid);
    shift_n = load ? hold : shift;
    idx_n = (load || word_end) ? '0 : adv ? idx + IW'(1) : idx;
    state_n = state;
    if (load) state_n = SHIFT;
    else if (word_end) state_n = IDLE;
  end
  // state, data registers and registered outputs computed from the next state
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      dataReady <= 1'b1;
      idx <= '0;
      shift <= '0;
      hold <= '0;
      serialOut <= IDLE_LEVEL;
      frameStart <= 1'b0;
      wordDone <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      dataReady <= ready_n;
      idx <= idx_n;
      shift <= shift_n;
      if (dataValid && dataReady) hold <= dataIn;
      serialOut <= (state_n == SHIFT) ? shift_n[idx_n] : IDLE_LEVEL;
      frameStart <= load;
      wordDone <= state_n == SHIFT && idx_n == LAST_BIT && last_ahead;
      busy <= state_n == SHIFT;
    end
endmodule

// File: tb/tb_parallel_bit_streamer.sv
// tb_parallel_bit_streamer: directed vector table plus corner-case sequences
module tb_parallel_bit_streamer;
  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [5:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] data1 = '0, data3 = '0;
  logic valid1 = 1'b0, valid3 = 1'b0;
  logic ready1, serial1, strobe1, frame1, done1, busy1;
  logic ready3, serial3, strobe3, frame3, done3, busy3;
  int n_vec = 0, n_bad = 0;
  int cap_n, frames, lows, guard;
  logic [23:0] cap;
  logic [7:0] b8;
  vec_t vecs[$];

  always #5 clk = ~clk;

  parallel_bit_streamer #(.BIT_PERIOD(1)) u1 (
    .clk(clk), .rst(rst), .dataIn(data1), .dataValid(valid1), .dataReady(ready1),
    .serialOut(serial1), .bitStrobe(strobe1), .frameStart(frame1), .wordDone(done1), .busy(busy1)
  );
  parallel_bit_streamer #(.BIT_PERIOD(3)) u3 (
    .clk(clk), .rst(rst), .dataIn(data3), .dataValid(valid3), .dataReady(ready3),
    .serialOut(serial3), .bitStrobe(strobe3), .frameStart(frame3), .wordDone(done3), .busy(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [5:0] e);
    vecs.push_back('{r, v, d, e});
  endtask

  task automatic tick_cap();
    tick();
    if (cap_n < 24) begin
      cap[cap_n] = serial1;
      frames += int'(frame1);
      cap_n++;
    end
  endtask

  initial begin
    // expected bits: {ready, serial, strobe, frame, done, busy}
    add(1, 0, 8'h00, 6'b100000);
    add(0, 1, 8'hA5, 6'b000000);
    add(0, 0, 8'h00, 6'b111101);
    add(0, 0, 8'h00, 6'b101001);
    add(0, 0, 8'h00, 6'b111001);
    add(0, 0, 8'h00, 6'b101001);
    add(0, 0, 8'h00, 6'b101001);
    add(0, 0, 8'h00, 6'b111001);
    add(0, 0, 8'h00, 6'b101001);
    add(0, 0, 8'h00, 6'b111011);
    add(0, 0, 8'h00, 6'b100000);
    add(0, 1, 8'h01, 6'b000000);
    add(0, 1, 8'hFF, 6'b111101);
    add(0, 1, 8'hFF, 6'b001001);
    for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 6'b001001);
    add(0, 0, 8'h00, 6'b001011);
    add(0, 0, 8'h00, 6'b111101);
    for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 6'b111001);
    add(0, 0, 8'h00, 6'b111011);
    add(0, 0, 8'h00, 6'b100000);

    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle1_c%0d", i), {ready1, serial1, strobe1, frame1, done1, busy1}, 6'b100000);
      chk($sformatf("idle3_c%0d", i), {ready3, serial3, strobe3, frame3, done3, busy3}, 6'b100000);
    end

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      valid1 = vecs[i].valid;
      data1 = vecs[i].data;
      tick();
      chk($sformatf("vec%0d", i), {ready1, serial1, strobe1, frame1, done1, busy1}, vecs[i].exp);
    end
    rst = 1'b0;
    valid1 = 1'b0;

    valid1 = 1'b1;
    data1 = 8'h55;
    tick();
    data1 = 8'hAA;
    cap_n = 0;
    frames = 0;
    tick_cap();
    tick_cap();
    data1 = 8'h3C;
    lows = 0;
    while (!ready1 && lows < 20) begin
      lows++;
      tick_cap();
    end
    chk("bp_ready_low_cycles", lows, 7);
    tick_cap();
    valid1 = 1'b0;
    guard = 0;
    while (cap_n < 24 && guard < 40) begin
      guard++;
      tick_cap();
    end
    chk("bp_stream", cap, 24'h3CAA55);
    chk("bp_frames", frames, 3);
    tick();
    chk("bp_idle", {busy1, serial1}, 2'b00);

    chk("bp3_ready", ready3, 1'b1);
    valid3 = 1'b1;
    data3 = 8'h80;
    tick();
    valid3 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk($sformatf("bp3_c%0d", c), {serial3, strobe3, done3, busy3}, {c >= 22, c % 3 == 1, c == 24, 1'b1});
    end
    tick();
    chk("bp3_idle", {busy3, serial3, strobe3}, 3'b000);

    valid1 = 1'b1;
    data1 = 8'hF0;
    tick();
    data1 = 8'h0F;
    tick();
    tick();
    valid1 = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_bit4", {serial1, ready1}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid", {ready1, serial1, strobe1, frame1, done1, busy1}, 6'b100000);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rst_quiet_c%0d", i), {busy1, serial1, frame1}, 3'b000);
    end
    valid1 = 1'b1;
    data1 = 8'h81;
    tick();
    valid1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      b8[i] = serial1;
      if (i == 0) chk("rst_next_frame", frame1, 1'b1);
    end
    chk("rst_next_word", b8, 8'h81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
